// File: rtl/counter_event_monitor_if.sv
// Event drain port of counter_event_monitor: show-ahead FIFO head with valid/ready.
interface counter_event_monitor_if #(
  parameter int DATA_W = 14
);
  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/counter_event_monitor.sv
// Watches an enable/clear up-counter, checks each step and queues timestamped
// START/STOP/WRAP/ERR events in a small show-ahead FIFO.
module counter_event_monitor #(
  parameter int CNT_W = 4,
  parameter int TS_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cnt_clear,
  input  logic                      enable,
  input  logic [CNT_W-1:0]          counter_in,
  counter_event_monitor_if.master   evt,
  output logic [7:0]                wrap_count,
  output logic                      err_flag,
  output logic                      ovf_flag
);

  localparam int AW  = $clog2(DEPTH);
  localparam int E_W = 2 + CNT_W + TS_W;

  localparam logic [1:0] T_START = 2'd0;
  localparam logic [1:0] T_STOP  = 2'd1;
  localparam logic [1:0] T_WRAP  = 2'd2;
  localparam logic [1:0] T_ERR   = 2'd3;

  logic [TS_W-1:0]  r_ts;
  logic             r_prev_valid;
  logic             r_prev_clear;
  logic             r_prev_en;
  logic [CNT_W-1:0] r_prev_cnt;

  logic [E_W-1:0]   r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic [CNT_W-1:0] w_exp;
  logic             w_err;
  logic             w_wrap;
  logic             w_start;
  logic             w_stop;
  logic             w_evt;
  logic [1:0]       w_type;
  logic [E_W-1:0]   w_entry;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;

  always_comb begin
    w_exp = r_prev_cnt;
    if (r_prev_clear)
      w_exp = '0;
    else if (r_prev_en)
      w_exp = r_prev_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign w_err   = r_prev_valid && (counter_in != w_exp);
  assign w_wrap  = r_prev_valid && r_prev_en && !r_prev_clear &&
                   (r_prev_cnt == {CNT_W{1'b1}}) && (counter_in == '0);
  assign w_start = r_prev_valid && enable && !r_prev_en;
  assign w_stop  = r_prev_valid && !enable && r_prev_en;
  assign w_evt   = w_err || w_wrap || w_start || w_stop;

  // One event per edge: ERR > WRAP > START > STOP.
  always_comb begin
    w_type = T_STOP;
    if (w_err)
      w_type = T_ERR;
    else if (w_wrap)
      w_type = T_WRAP;
    else if (w_start)
      w_type = T_START;
  end

  assign w_entry = {w_type, counter_in, r_ts};

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && evt.evt_ready;
  assign w_push  = w_evt && (!w_full || w_pop);

  assign evt.evt_valid = !w_empty;
  assign evt.evt_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ts         <= '0;
      r_prev_valid <= 1'b0;
      r_prev_clear <= 1'b0;
      r_prev_en    <= 1'b0;
      r_prev_cnt   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      wrap_count   <= 8'd0;
      err_flag     <= 1'b0;
      ovf_flag     <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      r_ts         <= r_ts + {{(TS_W-1){1'b0}}, 1'b1};
      r_prev_valid <= 1'b1;
      r_prev_clear <= cnt_clear;
      r_prev_en    <= enable;
      r_prev_cnt   <= counter_in;
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_err)
        err_flag <= 1'b1;
      // Detection side effects apply even when the push itself is dropped.
      if (w_wrap && (wrap_count != 8'hFF))
        wrap_count <= wrap_count + 8'd1;
      if (w_evt && w_full && !w_pop)
        ovf_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_event_monitor.sv
// Self-checking bench for counter_event_monitor: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_counter_event_monitor;

  localparam int CNT_W = 4;
  localparam int TS_W  = 8;
  localparam int DEPTH = 4;
  localparam int E_W   = 2 + CNT_W + TS_W;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cnt_clear = 1'b0;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] counter_in = '0;
  logic [7:0]       wrap_count;
  logic             err_flag;
  logic             ovf_flag;

  counter_event_monitor_if #(.DATA_W(E_W)) evt_if ();

  counter_event_monitor #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .cnt_clear  (cnt_clear),
    .enable     (enable),
    .counter_in (counter_in),
    .evt        (evt_if.master),
    .wrap_count (wrap_count),
    .err_flag   (err_flag),
    .ovf_flag   (ovf_flag)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int edges = 0;

  // Reference model state
  int             m_ts;
  bit             m_pv;
  bit             m_pc;
  bit             m_pe;
  int             m_pcnt;
  logic [E_W-1:0] m_q[$];
  int             m_wrap;
  bit             m_err;
  bit             m_ovf;

  function automatic logic [E_W-1:0] ent(input int t, input int c, input int ts);
    logic [1:0]       tt;
    logic [CNT_W-1:0] cc;
    logic [TS_W-1:0]  ss;
    tt = t[1:0];
    cc = c[CNT_W-1:0];
    ss = ts[TS_W-1:0];
    return {tt, cc, ss};
  endfunction

  task automatic model_clear();
    m_ts = 0; m_pv = 0; m_pc = 0; m_pe = 0; m_pcnt = 0;
    m_q.delete(); m_wrap = 0; m_err = 0; m_ovf = 0;
    edges = 0;
  endtask

  // Drive inputs for one edge, advance to 1 time unit after it, update the model.
  task automatic step(input bit clr, input bit en, input int cnt, input bit rdy);
    int  exp_v;
    bit  e_err, e_wrap, e_start, e_stop, pop;
    int  typ;
    cnt_clear       = clr;
    enable          = en;
    counter_in      = cnt[CNT_W-1:0];
    evt_if.evt_ready = rdy;
    e_err = 0; e_wrap = 0; e_start = 0; e_stop = 0;
    if (m_pv) begin
      if (m_pc) exp_v = 0;
      else if (m_pe) exp_v = (m_pcnt + 1) % 16;
      else exp_v = m_pcnt;
      e_err   = (cnt % 16) != exp_v;
      e_wrap  = m_pe && !m_pc && (m_pcnt == 15) && ((cnt % 16) == 0);
      e_start = en && !m_pe;
      e_stop  = !en && m_pe;
    end
    pop = (m_q.size() > 0) && rdy;
    @(posedge clock);
    #1;
    if (pop) void'(m_q.pop_front());
    if (e_err || e_wrap || e_start || e_stop) begin
      typ = e_err ? 3 : (e_wrap ? 2 : (e_start ? 0 : 1));
      if (m_q.size() < DEPTH) m_q.push_back(ent(typ, cnt % 16, m_ts));
      else m_ovf = 1;
    end
    if (e_err) m_err = 1;
    if (e_wrap && m_wrap < 255) m_wrap++;
    m_ts = (m_ts + 1) % 256;
    m_pv = 1; m_pc = clr; m_pe = en; m_pcnt = cnt % 16;
    edges++;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    cnt_clear = 0; enable = 0; counter_in = '0; evt_if.evt_ready = 0;
    #4;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", evt_if.evt_valid); end
    if (evt_if.evt_data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", evt_if.evt_data); end
    if (wrap_count !== 8'd0) begin failures++; $display("FAIL reset_wrap got=%0d want=0", wrap_count); end
    if (err_flag !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err_flag); end
    if (ovf_flag !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf_flag); end
  endtask

  task automatic test_quiet();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL quiet_valid edge=%0d got=%b want=0", i, evt_if.evt_valid); end
    end
    checks += 3;
    if (wrap_count !== 8'd0) begin failures++; $display("FAIL quiet_wrap got=%0d want=0", wrap_count); end
    if (err_flag !== 1'b0) begin failures++; $display("FAIL quiet_err got=%b want=0", err_flag); end
    if (ovf_flag !== 1'b0) begin failures++; $display("FAIL quiet_ovf got=%b want=0", ovf_flag); end
  endtask

  task automatic test_full_run();
    int e;
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    e = edges;
    step(0, 1, 0, 0);
    for (int i = 1; i < 16; i++) step(0, 1, i, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    checks += 4;
    if (wrap_count !== 8'd1) begin failures++; $display("FAIL run_wrap_count got=%0d want=1", wrap_count); end
    if (err_flag !== 1'b0) begin failures++; $display("FAIL run_err got=%b want=0", err_flag); end
    if (evt_if.evt_valid !== 1'b1) begin failures++; $display("FAIL run_valid got=%b want=1", evt_if.evt_valid); end
    if (evt_if.evt_data !== ent(0, 0, e)) begin failures++; $display("FAIL run_start got=%h want=%h", evt_if.evt_data, ent(0, 0, e)); end
    step(0, 0, 1, 1);
    checks++;
    if (evt_if.evt_data !== ent(2, 0, e + 16)) begin failures++; $display("FAIL run_wrap got=%h want=%h", evt_if.evt_data, ent(2, 0, e + 16)); end
    step(0, 0, 1, 1);
    checks++;
    if (evt_if.evt_data !== ent(1, 1, e + 17)) begin failures++; $display("FAIL run_stop got=%h want=%h", evt_if.evt_data, ent(1, 1, e + 17)); end
    step(0, 0, 1, 1);
    checks++;
    if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL run_empty got=%b want=0", evt_if.evt_valid); end
  endtask

  task automatic test_clear();
    int ts_err;
    do_reset();
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 1; i < 9; i++) step(0, 1, i, 0);
    step(1, 1, 9, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    checks += 3;
    if (err_flag !== 1'b0) begin failures++; $display("FAIL clear_err got=%b want=0", err_flag); end
    if (wrap_count !== 8'd0) begin failures++; $display("FAIL clear_wrap got=%0d want=0", wrap_count); end
    if (evt_if.evt_data !== ent(0, 0, 1)) begin failures++; $display("FAIL clear_head got=%h want=%h", evt_if.evt_data, ent(0, 0, 1)); end
    step(0, 1, 2, 1);
    checks++;
    if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL clear_only_start got=%b want=0", evt_if.evt_valid); end
    step(1, 1, 3, 0);
    ts_err = edges;
    step(0, 1, 4, 0);
    checks += 2;
    if (err_flag !== 1'b1) begin failures++; $display("FAIL clear_miss_err got=%b want=1", err_flag); end
    if (evt_if.evt_data !== ent(3, 4, ts_err)) begin failures++; $display("FAIL clear_miss_entry got=%h want=%h", evt_if.evt_data, ent(3, 4, ts_err)); end
  endtask

  task automatic test_error();
    do_reset();
    step(0, 0, 3, 0);
    step(0, 1, 3, 0);
    step(0, 1, 5, 0);
    step(0, 1, 6, 0);
    checks += 2;
    if (err_flag !== 1'b1) begin failures++; $display("FAIL err_flag got=%b want=1", err_flag); end
    if (evt_if.evt_data !== ent(0, 3, 1)) begin failures++; $display("FAIL err_start got=%h want=%h", evt_if.evt_data, ent(0, 3, 1)); end
    step(0, 1, 7, 1);
    checks += 2;
    if (evt_if.evt_data !== ent(3, 5, 2)) begin failures++; $display("FAIL err_entry got=%h want=%h", evt_if.evt_data, ent(3, 5, 2)); end
    if (err_flag !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", err_flag); end
  endtask

  task automatic test_overflow();
    logic [E_W-1:0] exp_e[4];
    int pops, c;
    exp_e[0] = ent(0, 0, 1); exp_e[1] = ent(1, 1, 2);
    exp_e[2] = ent(0, 1, 3); exp_e[3] = ent(1, 2, 4);
    do_reset();
    step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 1, 0);
    step(0, 1, 1, 0); step(0, 0, 2, 0); step(0, 1, 2, 0);
    checks++;
    if (ovf_flag !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", ovf_flag); end
    pops = 0; c = 3;
    while (evt_if.evt_valid === 1'b1 && pops < 10) begin
      if (pops < 4) begin
        checks++;
        if (evt_if.evt_data !== exp_e[pops]) begin failures++; $display("FAIL ovf_order idx=%0d got=%h want=%h", pops, evt_if.evt_data, exp_e[pops]); end
      end
      step(0, 1, c, 1);
      c++; pops++;
    end
    checks += 2;
    if (pops != 4) begin failures++; $display("FAIL ovf_pops got=%0d want=4", pops); end
    if (ovf_flag !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", ovf_flag); end
  endtask

  task automatic test_back_to_back();
    logic [E_W-1:0] exp_e[4];
    int pops, c;
    exp_e[0] = ent(1, 1, 2); exp_e[1] = ent(0, 1, 3);
    exp_e[2] = ent(1, 2, 4); exp_e[3] = ent(0, 2, 5);
    do_reset();
    step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 1, 0);
    step(0, 1, 1, 0); step(0, 0, 2, 0);
    step(0, 1, 2, 1);
    checks += 2;
    if (ovf_flag !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b want=0", ovf_flag); end
    if (evt_if.evt_data !== exp_e[0]) begin failures++; $display("FAIL b2b_head got=%h want=%h", evt_if.evt_data, exp_e[0]); end
    pops = 0; c = 3;
    while (evt_if.evt_valid === 1'b1 && pops < 10) begin
      if (pops < 4) begin
        checks++;
        if (evt_if.evt_data !== exp_e[pops]) begin failures++; $display("FAIL b2b_order idx=%0d got=%h want=%h", pops, evt_if.evt_data, exp_e[pops]); end
      end
      step(0, 1, c, 1);
      c++; pops++;
    end
    checks++;
    if (pops != 4) begin failures++; $display("FAIL b2b_pops got=%0d want=4", pops); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 1, 5, 0);
    checks += 2;
    if (err_flag !== 1'b1) begin failures++; $display("FAIL areset_pre_err got=%b want=1", err_flag); end
    if (evt_if.evt_valid !== 1'b1) begin failures++; $display("FAIL areset_pre_valid got=%b want=1", evt_if.evt_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks += 3;
    if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b want=0", evt_if.evt_valid); end
    if (err_flag !== 1'b0) begin failures++; $display("FAIL areset_err got=%b want=0", err_flag); end
    if (ovf_flag !== 1'b0) begin failures++; $display("FAIL areset_ovf got=%b want=0", ovf_flag); end
    #2;
    reset = 1'b0;
    model_clear();
    step(0, 1, 0, 0);
    checks++;
    if (evt_if.evt_valid !== 1'b0) begin failures++; $display("FAIL areset_first_edge got=%b want=0", evt_if.evt_valid); end
    step(0, 0, 1, 0);
    checks++;
    if (evt_if.evt_data !== ent(1, 1, 1)) begin failures++; $display("FAIL areset_ts got=%h want=%h", evt_if.evt_data, ent(1, 1, 1)); end
  endtask

  task automatic test_wrap_sat();
    int c;
    do_reset();
    step(0, 0, 0, 1);
    c = 0;
    step(0, 1, 0, 1);
    for (int i = 0; i < 16 * 257; i++) begin
      c = (c + 1) % 16;
      step(0, 1, c, 1);
    end
    checks += 2;
    if (wrap_count !== 8'd255) begin failures++; $display("FAIL wrap_sat got=%0d want=255", wrap_count); end
    if (err_flag !== 1'b0) begin failures++; $display("FAIL wrap_sat_err got=%b want=0", err_flag); end
  endtask

  task automatic test_random();
    int c, pres;
    bit clr, en, rdy;
    do_reset();
    c = 0;
    for (int i = 0; i < 600; i++) begin
      clr = ($urandom % 10) == 0;
      en  = ($urandom % 3) != 0;
      rdy = ($urandom % 3) == 0;
      pres = (($urandom % 25) == 0) ? int'($urandom % 16) : c;
      step(clr, en, pres, rdy);
      c = clr ? 0 : (en ? (c + 1) % 16 : c);
      checks += 4;
      if (evt_if.evt_valid !== (m_q.size() > 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, evt_if.evt_valid, m_q.size() > 0); end
      if (wrap_count !== m_wrap[7:0]) begin failures++; $display("FAIL rnd_wrap cyc=%0d got=%0d want=%0d", i, wrap_count, m_wrap); end
      if (err_flag !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", i, err_flag, m_err); end
      if (ovf_flag !== m_ovf) begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%b want=%b", i, ovf_flag, m_ovf); end
      if (m_q.size() > 0) begin
        checks++;
        if (evt_if.evt_data !== m_q[0]) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", i, evt_if.evt_data, m_q[0]); end
      end
    end
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    test_reset();
    test_quiet();
    test_full_run();
    test_clear();
    test_error();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_wrap_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
